// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - registered N-to-1 channel mux with fixed-select or round-robin grant
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SELW:0]   NCH_EXT  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] PTR_INIT = SELW'(NCH - 1);

    logic [WIDTH-1:0] ch [NCH];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic [SELW-1:0]  cand;
    logic             xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign load_en = !out_valid_q || out_ready;

    // Round-robin search starts just after the last accepted channel and wraps.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (!mode) begin
            if (({1'b0, sel} < NCH_EXT) && in_valid[sel]) begin
                gnt_valid = 1'b1;
                gnt_idx   = sel;
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                cand = SELW'((int'(ptr_q) + k) % NCH);
                if (!gnt_valid && in_valid[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign xfer = rst_n && load_en && gnt_valid;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = ch[gnt_idx];
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= PTR_INIT;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// tb/tb_mux_arb_n.sv - scoreboard bench for mux_arb_n against a queue-based reference model
module tb_mux_arb_n;

    localparam int W = 32;
    localparam int N = 4;
    localparam int S = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N*W-1:0]   in_data = '0;
    logic [N-1:0]     in_valid = '0;
    logic [N-1:0]     in_ready;
    logic             mode = 1'b0;
    logic [S-1:0]     sel = '0;
    logic [W-1:0]     out_data;
    logic [S-1:0]     out_chan;
    logic             out_valid;
    logic             out_ready = 1'b0;

    mux_arb_n #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          mptr = N - 1;
    bit          mfull = 1'b0;
    int          fix_ch = -1;
    logic [W-1:0] fix_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: grant chosen from the rules, register occupancy tracked as a flag.
    task automatic model();
        bit           gv = 1'b0;
        int           g = 0;
        bit           load;
        logic [N-1:0] exp_ready = '0;
        load = !mfull || out_ready;
        if (rst_n) begin
            if (mode == 1'b0) begin
                if (int'(sel) < N && in_valid[sel]) begin
                    gv = 1'b1;
                    g = int'(sel);
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c = (mptr + k) % N;
                    if (!gv && in_valid[c]) begin
                        gv = 1'b1;
                        g = c;
                    end
                end
            end
        end
        if (load && gv) exp_ready[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(mfull));
        if (!rst_n) begin
            mfull = 1'b0;
            mptr = N - 1;
            sb.delete();
        end else if (load && gv) begin
            exp_t e;
            e.d = in_data[g*W +: W];
            e.c = g;
            sb.push_back(e);
            mptr = g;
            mfull = 1'b1;
        end else if (mfull && out_ready) begin
            mfull = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit m, input int s, input logic [N-1:0] v, input bit ordy);
        @(posedge clk);
        #1;
        rst_n = r;
        mode = m;
        sel = S'(s);
        in_valid = v;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
        if (fix_ch >= 0) in_data[fix_ch*W +: W] = fix_val;
        @(negedge clk);
        model();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty actual=out_valid=1 required=no word pending at %0t", $time);
                end else begin
                    chk("out_data", 64'(out_data), 64'(sb[0].d));
                    chk("out_chan", 64'(out_chan), 64'(sb[0].c));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 0, 4'hF, 1'b1);
            chk("rst_out_data", 64'(out_data), 64'h0);
            chk("rst_out_chan", 64'(out_chan), 64'h0);
            chk("rst_in_ready", 64'(in_ready), 64'h0);
        end

        step(1'b1, 1'b1, 0, 4'hF, 1'b1);
        chk("rr_first_ready", 64'(in_ready), 64'b0001);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 1'b1, 0, 4'hF, 1'b1);
            chk("rr_seq_chan", 64'(out_chan), 64'((j - 1) % N));
            chk("rr_seq_valid", 64'(out_valid), 64'h1);
        end

        fix_ch = 2;
        fix_val = 32'hDEADBEEF;
        step(1'b1, 1'b0, 2, 4'hF, 1'b1);
        chk("fix_ready", 64'(in_ready), 64'b0100);
        step(1'b1, 1'b0, 2, 4'b1011, 1'b1);
        chk("fix_data", 64'(out_data), 64'hDEADBEEF);
        chk("fix_chan", 64'(out_chan), 64'h2);
        chk("fix_noxfer_ready", 64'(in_ready), 64'h0);
        step(1'b1, 1'b0, 2, 4'b1011, 1'b1);
        chk("fix_drained", 64'(out_valid), 64'h0);

        for (int j = 0; j < 4; j++) step(1'b1, 1'b1, 0, 4'b1010, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b1, 0, 4'b0010, 1'b1);
            chk("sparse_ready", 64'(in_ready), 64'b0010);
        end

        fix_ch = 0;
        fix_val = 32'h11;
        step(1'b1, 1'b0, 0, 4'b0001, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b1, 0, 4'hF, 1'b0);
            chk("bp_data", 64'(out_data), 64'h11);
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_ready", 64'(in_ready), 64'h0);
        end
        fix_ch = -1;
        step(1'b1, 1'b1, 0, 4'hF, 1'b1);
        chk("bp_release_ready", 64'(in_ready), 64'b0010);

        step(1'b1, 1'b0, 1, 4'hF, 1'b1);
        step(1'b1, 1'b1, 0, 4'hF, 1'b1);
        chk("mode_switch_ready", 64'(in_ready), 64'b0100);

        for (int j = 0; j < 400; j++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom), int'($urandom_range(0, N - 1)),
                 N'($urandom), ($urandom_range(0, 3) != 0));
        end
        step(1'b1, 1'b1, 0, 4'h0, 1'b1);
        step(1'b1, 1'b1, 0, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshaking. It is the next generation of the datapath 2:1 word mux. It selects one of NCH WIDTH-bit input channels, either by an explicit select or by round-robin arbitration, and holds the winner in a single output register stage. It sits between multiple producers (register-file read ports, immediate path, memory read data) and a single pipelined consumer that can stall.

## Interface
Parameters:
- WIDTH, 32: data word width in bits.
- NCH, 4: number of input channels; legal range is 2 to 16.
- SELW, 2: select/channel-index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

## Operation
- load_en = !out_valid || out_ready. The register accepts a new word when it is empty or is being drained in the same cycle.
- Grant in mode 0:
  - Channel sel is granted if in_valid[sel] = 1.
  - If sel >= NCH, no channel is granted and in_ready is all zeros.
- Grant in mode 1:
  - Search from ptr+1 upward, wrapping modulo NCH.
  - The first channel with in_valid = 1 is granted.
  - ptr is the index of the last accepted channel.
- in_ready[i] = load_en && (grant valid) && (grant index == i). At most one bit is ever set.
- A transfer on channel g happens when in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← channel g data.
  - out_chan ← g.
  - out_valid ← 1.
  - ptr ← g, in either mode.
- When out_valid && out_ready and there is no new transfer: out_valid ← 0. out_data and out_chan hold their last values.
- When out_valid && !out_ready: out_data, out_chan and out_valid hold, and in_ready is all zeros. This is backpressure.
- ptr updates in both modes, so a switch to mode 1 continues from the last channel used.
- A mode or sel change takes effect on the grant in the same cycle. A word already in the register is unaffected.
- Input channels must hold data stable while valid && !ready. The block does not check this.
- in_data is only sampled on a transfer. Channels that do not win keep their valid asserted and are not dropped.

## Timing
- Reset values (rst_n low at an edge): out_valid = 0, out_data = 0, out_chan = 0, ptr = NCH-1. In mode 1 after reset, channel 0 has first priority.
- While rst_n is low, in_ready is all zeros. A word in flight when reset arrives mid-stream is discarded.
- Latency: 1 cycle from transfer to out_valid/out_data.
- Throughput: 1 word per cycle while out_ready = 1.
- Round-robin fairness: with all channels continuously valid and out_ready = 1, grants go 0,1,…,NCH-1,0,… with no channel skipped. The worst-case wait for a valid channel is NCH-1 transfers.
- Wrap-around: with ptr = NCH-1, the search starts at channel 0.
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. There is no combinational path from in_data to any output.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with all in_valid = 1 → out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0000. Release in mode 1 → first transfer is channel 0, and out_valid = 1 one cycle later.
- **Fixed select, NCH = 4, WIDTH = 32:** mode = 0, sel = 2, ch2 = 0xDEADBEEF, all valid, out_ready = 1 → in_ready = 0100, and next cycle out_data = 0xDEADBEEF, out_chan = 2. Then set sel = 2 with in_valid[2] = 0 → no transfer, and out_valid drops to 0 after the drain.
- **Round-robin, all valid, out_ready = 1 for 8 cycles** → out_chan sequence 0,1,2,3,0,1,2,3 with back-to-back out_valid = 1.
- **Sparse round-robin:** only channels 1 and 3 valid → out_chan alternates 1,3,1,3. Drop ch3 → ch1 repeats every cycle.
- **Backpressure:** out_ready = 0 for 4 cycles while holding out_data = 0x11 → out_data, out_chan and out_valid are stable, and in_ready = 0000. When out_ready returns to 1, a new word loads in that same cycle with no bubble.
- **Mode switch:** in mode 0 accept sel = 1, then switch to mode 1 with all valid → next grant is channel 2, because ptr = 1.
